// File: rtl/ili_init_seq.sv
// ILI-style panel init sequencer: panel reset timing, then byte stream from an init table.
// Optional macro ILI_INIT_SEQ_DELAY_EN enables millisecond delay entries in the table.
module ili_init_seq #(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 6,
  parameter int unsigned MS_CYC      = 100000,
  parameter int unsigned RST_LO_MS   = 15,
  parameter int unsigned RST_WAIT_MS = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          tx_ready,
  output logic [AW-1:0] rom_addr,
  input  logic [DW+2:0] rom_data,
  output logic          cs,
  output logic          dc,
  output logic          reset,
  output logic          send,
  output logic [DW-1:0] data,
  output logic          busy,
  output logic          done
);

  localparam int unsigned MAX_MS = (RST_WAIT_MS > 255) ? RST_WAIT_MS : 255;
  localparam int unsigned TW     = $clog2(MAX_MS * MS_CYC + 1);

  localparam logic [TW-1:0] LIM_HI   = TW'(MS_CYC - 1);
  localparam logic [TW-1:0] LIM_LO   = TW'(RST_LO_MS * MS_CYC - 1);
  localparam logic [TW-1:0] LIM_WAIT = TW'(RST_WAIT_MS * MS_CYC - 1);

  typedef enum logic [3:0] {
    IDLE,
    RST_HI,
    RST_LO,
    RST_WAIT,
    CS_INI,
    FETCH,
    SEND,
`ifdef ILI_INIT_SEQ_DELAY_EN
    DLY,
`endif
    CS_END,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            dc_q;
  logic            last_q;
  logic            ena_q;
  logic            addr_inc;
`ifdef ILI_INIT_SEQ_DELAY_EN
  logic [TW-1:0]   dly_lim_q;
`endif

  logic          ena_rise;
  logic          ent_dly, ent_last, ent_dc;
  logic [DW-1:0] ent_byte;
  logic          addr_top, fin_r;

  assign ena_rise = ena & ~ena_q;
  assign ent_dly  = rom_data[DW+2];
  assign ent_last = rom_data[DW+1];
  assign ent_dc   = rom_data[DW];
  assign ent_byte = rom_data[DW-1:0];
  assign addr_top = (addr_q == '1);
  assign fin_r    = last_q | addr_top;

  always_comb begin
    state_d  = state_q;
    addr_inc = 1'b0;
    case (state_q)
      IDLE, DONE: if (ena_rise) state_d = RST_HI;
      RST_HI:     if (tmr_q == LIM_HI) state_d = RST_LO;
      RST_LO:     if (tmr_q == LIM_LO) state_d = RST_WAIT;
      RST_WAIT:   if (tmr_q == LIM_WAIT) state_d = CS_INI;
      CS_INI:     state_d = FETCH;
      FETCH: begin
        if (!ent_dly) begin
          state_d = SEND;
        end else begin
`ifdef ILI_INIT_SEQ_DELAY_EN
          state_d = DLY;
`else
          // delay entry is consumed by this FETCH cycle alone
          if (ent_last | addr_top) state_d = CS_END;
          else addr_inc = 1'b1;
`endif
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (fin_r) begin
            state_d = CS_END;
          end else begin
            state_d  = FETCH;
            addr_inc = 1'b1;
          end
        end
      end
`ifdef ILI_INIT_SEQ_DELAY_EN
      DLY: begin
        if (tmr_q == dly_lim_q) begin
          if (fin_r) begin
            state_d = CS_END;
          end else begin
            state_d  = FETCH;
            addr_inc = 1'b1;
          end
        end
      end
`endif
      CS_END:     state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // ena_q resets high so a level held through reset is not taken as a start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      dc_q      <= 1'b1;
      last_q    <= 1'b0;
      ena_q     <= 1'b1;
`ifdef ILI_INIT_SEQ_DELAY_EN
      dly_lim_q <= '0;
`endif
    end else begin
      ena_q   <= ena;
      state_q <= state_d;
      tmr_q   <= (state_d != state_q) ? '0 : tmr_q + TW'(1);
      if (state_q == CS_INI) addr_q <= '0;
      else if (addr_inc)     addr_q <= addr_q + AW'(1);
      if (state_q == FETCH) begin
        last_q <= ent_last;
        if (!ent_dly) begin
          data_q <= ent_byte;
          dc_q   <= ent_dc;
        end
`ifdef ILI_INIT_SEQ_DELAY_EN
        // zero-length delay still spends one cycle in DLY
        dly_lim_q <= (ent_byte == '0) ? '0
                   : TW'(TW'(ent_byte) * TW'(MS_CYC) - TW'(1));
`endif
      end
    end
  end

  always_comb begin
    cs = 1'b1;
    case (state_q)
      CS_INI, FETCH, SEND: cs = 1'b0;
`ifdef ILI_INIT_SEQ_DELAY_EN
      DLY:                 cs = 1'b0;
`endif
      default:             cs = 1'b1;
    endcase
  end

  assign reset    = (state_q != RST_LO);
  assign send     = (state_q == SEND);
  assign data     = data_q;
  assign dc       = dc_q;
  assign rom_addr = addr_q;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_ili_init_seq.sv
// Directed self-checking bench for ili_init_seq with small timing parameters.
module tb_ili_init_seq;

  logic        clk, rst, ena, tx_ready;
  logic [2:0]  rom_addr;
  logic [10:0] rom_data;
  logic        cs, dc, reset, send, busy, done;
  logic [7:0]  data;

  logic [10:0] mem [8];
  assign rom_data = mem[rom_addr];

  ili_init_seq #(
    .DW(8), .AW(3), .MS_CYC(4), .RST_LO_MS(2), .RST_WAIT_MS(3)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .tx_ready(tx_ready),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cs(cs), .dc(dc), .reset(reset), .send(send), .data(data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ent(input logic d, input logic l, input logic c,
                                      input logic [7:0] b);
    return {d, l, c, b};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = '0;
  endtask

  // Delay-entry gaps between transfers: FETCH(delay) + DLY + FETCH(next) with the
  // feature on, FETCH(delay) + FETCH(next) with it off.
`ifdef ILI_INIT_SEQ_DELAY_EN
  localparam int GAP_D5 = 23;
  localparam int GAP_D0 = 4;
`else
  localparam int GAP_D5 = 3;
  localparam int GAP_D0 = 3;
`endif

  int          xq_n, send_cyc, stall_sends, cs_hi_busy;
  logic [8:0]  xq [16];
  int          xc [16];
  int          hi, lo, wt;

  task automatic start_seq();
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  // Entered at a negedge in the first RST_HI cycle (or later); exits in CS_INI.
  task automatic measure_reset();
    hi = 0; lo = 0; wt = 0;
    while (reset && hi < 100) begin hi++; @(negedge clk); end
    while (!reset && lo < 100) begin lo++; @(negedge clk); end
    while (cs && wt < 100) begin wt++; @(negedge clk); end
  endtask

  // Entered at CS_INI; cycle 0 is CS_INI. Runs until done or budget.
  task automatic collect(input logic [7:0] stall_byte, input int stall_len);
    int stall = stall_len;
    int cyc = 0;
    xq_n = 0; send_cyc = 0; stall_sends = 0; cs_hi_busy = 0;
    while (!done && cyc < 400) begin
      if (send && data == stall_byte && stall > 0) begin
        tx_ready = 1'b0;
        stall--;
      end else begin
        tx_ready = 1'b1;
      end
      if (send) send_cyc++;
      if (send && data == stall_byte && dc == 1'b0) stall_sends++;
      if (send && tx_ready && xq_n < 16) begin
        xq[xq_n] = {dc, data};
        xc[xq_n] = cyc;
        xq_n++;
      end
      if (cs && busy) cs_hi_busy++;
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b1;
    chk("done_reached", done, 1);
    chk("busy_at_done", busy, 0);
    chk("cs_at_done", cs, 1);
  endtask

  initial begin
    rst = 1'b0; ena = 1'b0; tx_ready = 1'b1;
    clear_mem();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_reset", reset, 1);
    chk("rst_cs", cs, 1);
    chk("rst_dc", dc, 1);
    chk("rst_send", send, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_addr", rom_addr, 3'd0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Basic table: cmd 0x01, data 0x36, last data 0x48
    mem[0] = ent(0, 0, 0, 8'h01);
    mem[1] = ent(0, 0, 1, 8'h36);
    mem[2] = ent(0, 1, 1, 8'h48);
    start_seq();
    chk("t2_busy_start", busy, 1);
    measure_reset();
    chk("t2_rst_hi", hi, 4);
    chk("t2_rst_lo", lo, 8);
    chk("t2_rst_wait", wt, 12);
    collect(8'h00, 0);
    chk("t2_nxfer", xq_n, 3);
    chk("t2_x0", xq[0], {1'b0, 8'h01});
    chk("t2_x1", xq[1], {1'b1, 8'h36});
    chk("t2_x2", xq[2], {1'b1, 8'h48});
    chk("t2_first_cyc", xc[0], 2);
    chk("t2_gap01", xc[1] - xc[0], 2);
    chk("t2_gap12", xc[2] - xc[1], 2);
    chk("t2_send_cycles", send_cyc, 3);
    chk("t2_cs_end_len", cs_hi_busy, 1);
    chk("t2_addr_end", rom_addr, 3'd2);

    // Restart from DONE; mid-sequence ena edge ignored; stall on 0x11
    clear_mem();
    mem[0] = ent(0, 0, 0, 8'h2A);
    mem[1] = ent(0, 0, 0, 8'h11);
    mem[2] = ent(0, 1, 1, 8'h99);
    start_seq();
    chk("t4_done_clr", done, 0);
    chk("t4_busy", busy, 1);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    measure_reset();
    chk("t4_rst_hi_rest", hi, 2);
    chk("t4_rst_lo", lo, 8);
    collect(8'h11, 5);
    chk("t4_nxfer", xq_n, 3);
    chk("t4_x1", xq[1], {1'b0, 8'h11});
    chk("t4_stall_stable", stall_sends, 6);
    chk("t4_send_cycles", send_cyc, 8);

    // Delay entries: 0x05 and 0x00
    clear_mem();
    mem[0] = ent(0, 0, 0, 8'h01);
    mem[1] = ent(1, 0, 0, 8'h05);
    mem[2] = ent(0, 0, 1, 8'h02);
    mem[3] = ent(1, 0, 0, 8'h00);
    mem[4] = ent(0, 1, 1, 8'h03);
    start_seq();
    measure_reset();
    collect(8'h00, 0);
    chk("t5_nxfer", xq_n, 3);
    chk("t5_gap_d5", xc[1] - xc[0], GAP_D5);
    chk("t5_gap_d0", xc[2] - xc[1], GAP_D0);
    chk("t5_x2", xq[2], {1'b1, 8'h03});
    chk("t5_cs_held", cs_hi_busy, 1);
    chk("t5_send_cycles", send_cyc, 3);

    // Full table without last flag: stop at entry 7, no wrap
    for (int i = 0; i < 8; i++) mem[i] = ent(0, 0, 1, 8'hA0 + 8'(i));
    start_seq();
    measure_reset();
    collect(8'h00, 0);
    chk("t6_nxfer", xq_n, 8);
    chk("t6_x7", xq[7], {1'b1, 8'hA7});
    chk("t6_addr_end", rom_addr, 3'd7);

    // Reset mid-SEND, then a fresh edge restarts from RST_HI
    clear_mem();
    mem[0] = ent(0, 1, 0, 8'h55);
    start_seq();
    measure_reset();
    tx_ready = 1'b0;
    for (int n = 0; n < 10 && !send; n++) @(negedge clk);
    chk("t7_in_send", send, 1);
    rst = 1'b0;
    #1;
    chk("t7_cs_async", cs, 1);
    chk("t7_send_async", send, 0);
    chk("t7_busy_async", busy, 0);
    chk("t7_addr_async", rom_addr, 3'd0);
    ena = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t7_no_autostart", busy, 0);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    start_seq();
    measure_reset();
    chk("t7_restart_hi", hi, 4);
    collect(8'h00, 0);
    chk("t7_nxfer", xq_n, 1);
    chk("t7_x0", xq[0], {1'b0, 8'h55});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
